msf_time_encoder: RTL and testbench

Generates a 60-second MSF time-code frame from BCD time/date fields. It produces the on/off carrier keying pattern, timed by an external 100 ms tick. It also emits a per-second `{B, A}` bit stream in the same format that `time_date_decoder` consumes, so the two blocks can be looped back for self-test. It sits beside the receive path as a local test-signal source and as the reference transmitter for verification.

---
 rtl/msf_time_encoder.sv | 164 ++++++++++++++++
 tb/tb_msf_time_encoder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/msf_time_encoder.sv
// msf_time_encoder
//
// Generates a 60-second MSF time-code frame from BCD time/date fields. The
// carrier keying pattern is stepped by an external 100 ms tick (ten slots per
// second). Once per second, at slot 5, the {B, A} bit pair for that second is
// reported in the format time_date_decoder consumes, so both blocks can be
// looped back for self-test.
//
// Ports
//   clk_i, rst_ni            system clock, asynchronous active-low reset
//   enable_i                 run when high; idle (carrier on, counters 0) when low
//   tick_i                   one-clock pulse every 100 ms, advances the slot
//   year_h_i .. minute_l_i   time/date fields for the minute starting at the
//                            next second 00 (latched on the tick entering it)
//   bst_i                    summer-time flag, sent as B58
//   carrier_o                1 = carrier on, 0 = carrier off (registered)
//   sec_o                    current second in the frame, 0-59
//   bits_valid_o             one-clock pulse per transmitted second
//   bits_is_second_00_o      qualifies bits_valid_o: second is 00
//   bits_data_o              {B, A} for the second just reported
//
// state | meaning
// IDLE  | carrier on, second/slot held at 0, waiting for an enabled tick
// RUN   | frame generation, advancing one slot per tick
module msf_time_encoder (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       enable_i,
    input  logic       tick_i,
    input  logic [3:0] year_h_i,
    input  logic [3:0] year_l_i,
    input  logic       month_h_i,
    input  logic [3:0] month_l_i,
    input  logic [1:0] day_h_i,
    input  logic [3:0] day_l_i,
    input  logic [2:0] dow_i,
    input  logic [1:0] hour_h_i,
    input  logic [3:0] hour_l_i,
    input  logic [2:0] minute_h_i,
    input  logic [3:0] minute_l_i,
    input  logic       bst_i,
    output logic       carrier_o,
    output logic [5:0] sec_o,
    output logic       bits_valid_o,
    output logic       bits_is_second_00_o,
    output logic [1:0] bits_data_o
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    logic [3:0]  slot;
    logic [5:0]  sec;
    // Frame register: A17..A51 packed MSB first, so A17 sits at bit 34.
    logic [34:0] frame;
    logic        frame_bst;

    logic [34:0] fields;
    logic [3:0]  slot_nxt;
    logic [5:0]  sec_nxt;
    logic        enter_frame;
    logic        a_nxt;
    logic        b_nxt;
    logic        key;

    assign fields = {year_h_i, year_l_i, month_h_i, month_l_i, day_h_i, day_l_i,
                     dow_i, hour_h_i, hour_l_i, minute_h_i, minute_l_i};

    function automatic logic a_of(input logic [5:0] s, input logic [34:0] f);
        logic [5:0] d;
        logic [7:0] tail;
        tail = 8'b0111_1110;   // A52..A59, A52 in the MSB
        d    = 6'd0;
        a_of = 1'b0;
        if (s >= 6'd17 && s <= 6'd51) begin
            d    = 6'd51 - s;
            a_of = f[d];
        end else if (s >= 6'd52 && s <= 6'd59) begin
            d    = 6'd59 - s;
            a_of = tail[d[2:0]];
        end
    endfunction

    // Odd parity: B is set when the covered A bits hold an even number of ones.
    function automatic logic b_of(input logic [5:0] s, input logic [34:0] f,
                                  input logic bst);
        case (s)
            6'd54:   b_of = ~^f[34:27];
            6'd55:   b_of = ~^f[26:16];
            6'd56:   b_of = ~^f[15:13];
            6'd57:   b_of = ~^f[12:0];
            6'd58:   b_of = bst;
            default: b_of = 1'b0;
        endcase
    endfunction

    always_comb begin
        slot_nxt    = 4'd0;
        sec_nxt     = 6'd0;
        enter_frame = 1'b1;
        if (state == RUN) begin
            if (slot == 4'd9) begin
                slot_nxt    = 4'd0;
                sec_nxt     = (sec == 6'd59) ? 6'd0 : sec + 6'd1;
                enter_frame = (sec == 6'd59);
            end else begin
                slot_nxt    = slot + 4'd1;
                sec_nxt     = sec;
                enter_frame = 1'b0;
            end
        end
        // Second 00 keying ignores A/B, so using the outgoing frame here is safe
        // even on the tick that latches the next one.
        a_nxt = a_of(sec_nxt, frame);
        b_nxt = b_of(sec_nxt, frame, frame_bst);
        if (sec_nxt == 6'd0) begin
            key = (slot_nxt >= 4'd5);
        end else begin
            key = !((slot_nxt == 4'd0) ||
                    (slot_nxt == 4'd1 && a_nxt) ||
                    (slot_nxt == 4'd2 && b_nxt));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state               <= IDLE;
            slot                <= 4'd0;
            sec                 <= 6'd0;
            frame               <= 35'd0;
            frame_bst           <= 1'b0;
            carrier_o           <= 1'b1;
            bits_valid_o        <= 1'b0;
            bits_is_second_00_o <= 1'b0;
            bits_data_o         <= 2'b00;
        end else if (!enable_i) begin
            state        <= IDLE;
            slot         <= 4'd0;
            sec          <= 6'd0;
            carrier_o    <= 1'b1;
            bits_valid_o <= 1'b0;
        end else begin
            bits_valid_o <= 1'b0;
            if (tick_i) begin
                state     <= RUN;
                slot      <= slot_nxt;
                sec       <= sec_nxt;
                carrier_o <= key;
                if (enter_frame) begin
                    frame     <= fields;
                    frame_bst <= bst_i;
                end
                if (slot_nxt == 4'd5) begin
                    bits_valid_o        <= 1'b1;
                    bits_is_second_00_o <= (sec_nxt == 6'd0);
                    bits_data_o         <= (sec_nxt == 6'd0) ? 2'b00 : {b_nxt, a_nxt};
                end
            end
        end
    end

    assign sec_o = sec;

endmodule

// File: tb/tb_msf_time_encoder.sv
module tb_msf_time_encoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       tick = 1'b0;
    logic [3:0] year_h = 4'd0, year_l = 4'd0, month_l = 4'd0, day_l = 4'd0;
    logic [3:0] hour_l = 4'd0, minute_l = 4'd0;
    logic       month_h = 1'b0, bst = 1'b0;
    logic [1:0] day_h = 2'd0, hour_h = 2'd0;
    logic [2:0] dow = 3'd0, minute_h = 3'd0;
    logic       carrier;
    logic [5:0] sec;
    logic       bits_valid, bits_is_00;
    logic [1:0] bits_data;

    msf_time_encoder dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .tick_i(tick),
        .year_h_i(year_h), .year_l_i(year_l), .month_h_i(month_h), .month_l_i(month_l),
        .day_h_i(day_h), .day_l_i(day_l), .dow_i(dow), .hour_h_i(hour_h),
        .hour_l_i(hour_l), .minute_h_i(minute_h), .minute_l_i(minute_l), .bst_i(bst),
        .carrier_o(carrier), .sec_o(sec), .bits_valid_o(bits_valid),
        .bits_is_second_00_o(bits_is_00), .bits_data_o(bits_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    typedef struct { int due; int car; int s; } cexp_t;
    typedef struct { int due; int is00; int data; int s; bit rec; } bexp_t;
    cexp_t cq[$];
    bexp_t bq[$];

    // Reference model: second/slot position and per-second A/B bit tables.
    bit m_run = 0;
    int m_sec = 0, m_slot = 0, m_frames = 0;
    int m_a[60];
    int m_b[60];
    bit rec_phase = 0;
    int obs[60];

    task automatic put(int start, int val, int w);
        for (int i = 0; i < w; i++) m_a[start + i] = (val >> (w - 1 - i)) & 1;
    endtask

    function automatic int ones(int lo, int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) n += m_a[i];
        return n;
    endfunction

    task automatic latch_fields();
        int tail[8] = '{0, 1, 1, 1, 1, 1, 1, 0};
        for (int i = 0; i < 60; i++) begin m_a[i] = 0; m_b[i] = 0; end
        put(17, int'(year_h), 4);  put(21, int'(year_l), 4);
        put(25, int'(month_h), 1); put(26, int'(month_l), 4);
        put(30, int'(day_h), 2);   put(32, int'(day_l), 4);
        put(36, int'(dow), 3);     put(39, int'(hour_h), 2);
        put(41, int'(hour_l), 4);  put(45, int'(minute_h), 3);
        put(48, int'(minute_l), 4);
        for (int i = 0; i < 8; i++) m_a[52 + i] = tail[i];
        m_b[54] = (ones(17, 24) % 2 == 0) ? 1 : 0;
        m_b[55] = (ones(25, 35) % 2 == 0) ? 1 : 0;
        m_b[56] = (ones(36, 38) % 2 == 0) ? 1 : 0;
        m_b[57] = (ones(39, 51) % 2 == 0) ? 1 : 0;
        m_b[58] = int'(bst);
        m_frames++;
    endtask

    function automatic int model_carrier();
        if (m_sec == 0) return (m_slot >= 5) ? 1 : 0;
        if (m_slot == 0) return 0;
        if (m_slot == 1 && m_a[m_sec] == 1) return 0;
        if (m_slot == 2 && m_b[m_sec] == 1) return 0;
        return 1;
    endfunction

    task automatic rand_fields();
        year_h = 4'($urandom_range(0, 15));  year_l = 4'($urandom_range(0, 15));
        month_h = 1'($urandom_range(0, 1));  month_l = 4'($urandom_range(0, 15));
        day_h = 2'($urandom_range(0, 3));    day_l = 4'($urandom_range(0, 15));
        dow = 3'($urandom_range(0, 7));      hour_h = 2'($urandom_range(0, 3));
        hour_l = 4'($urandom_range(0, 15));  minute_h = 3'($urandom_range(0, 7));
        minute_l = 4'($urandom_range(0, 15)); bst = 1'($urandom_range(0, 1));
    endtask

    task automatic step(bit en, bit tk, bit rnd);
        cexp_t c;
        bexp_t b;
        @(posedge clk);
        #1;
        if (rnd && $urandom_range(0, 3) == 0) rand_fields();
        enable = en;
        tick = tk;
        if (!en) begin
            m_run = 0; m_sec = 0; m_slot = 0;
            c.due = cyc + 1; c.car = 1; c.s = 0;
            cq.push_back(c);
        end else if (tk) begin
            if (!m_run) begin
                m_run = 1; m_sec = 0; m_slot = 0;
                latch_fields();
            end else begin
                m_slot++;
                if (m_slot == 10) begin
                    m_slot = 0;
                    m_sec = (m_sec + 1) % 60;
                    if (m_sec == 0) latch_fields();
                end
            end
            c.due = cyc + 1; c.car = model_carrier(); c.s = m_sec;
            cq.push_back(c);
            if (m_slot == 5) begin
                b.due = cyc + 1;
                b.is00 = (m_sec == 0) ? 1 : 0;
                b.data = (m_sec == 0) ? 0 : (m_b[m_sec] * 2 + m_a[m_sec]);
                b.s = m_sec;
                b.rec = rec_phase && (m_frames == 1);
                bq.push_back(b);
            end
        end
    endtask

    task automatic run_ticks(int n, bit rnd);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) step(1, 0, rnd);
            step(1, 1, rnd);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (cq.size() > 0 && cq[0].due == cyc) begin
                cexp_t c;
                c = cq.pop_front();
                chk("carrier", int'(carrier), c.car);
                chk("sec", int'(sec), c.s);
            end
            if (bits_valid) begin
                if (bq.size() == 0 || bq[0].due != cyc) begin
                    chk("unexpected_bits_valid", 1, 0);
                end else begin
                    bexp_t b;
                    b = bq.pop_front();
                    chk("bits_is_second_00", int'(bits_is_00), b.is00);
                    chk("bits_data", int'(bits_data), b.data);
                    if (b.rec) obs[b.s] = int'(bits_data);
                end
            end else if (bq.size() > 0 && bq[0].due == cyc) begin
                void'(bq.pop_front());
                chk("missing_bits_valid", 0, 1);
            end
        end
    end

    initial begin
        int v;
        int guard;
        for (int i = 0; i < 60; i++) obs[i] = 0;

        // Reset held
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_carrier", int'(carrier), 1);
        chk("rst_sec", int'(sec), 0);
        chk("rst_bits_valid", int'(bits_valid), 0);
        chk("rst_bits_data", int'(bits_data), 0);
        chk("rst_is00", int'(bits_is_00), 0);
        @(posedge clk); #1; rst_n = 1'b1;

        // Disabled with ticks running
        for (int i = 0; i < 20; i++) step(0, 1'($urandom_range(0, 1)), 0);

        // Directed frame 24-03-15 dow 5 13:47 BST
        year_h = 4'd2; year_l = 4'd4; month_h = 1'b0; month_l = 4'd3;
        day_h = 2'd1; day_l = 4'd5; dow = 3'd5; hour_h = 2'd1; hour_l = 4'd3;
        minute_h = 3'd4; minute_l = 4'd7; bst = 1'b1;
        rec_phase = 1;
        step(1, 1, 0);
        run_ticks(599, 1);
        rec_phase = 0;
        repeat (2) step(1, 0, 0);
        v = 0;
        for (int i = 17; i <= 24; i++) v = v * 2 + (obs[i] & 1);
        chk("a17_24", v, 8'b0010_0100);
        v = 0;
        for (int i = 54; i <= 58; i++) v = v * 2 + (obs[i] >> 1);
        chk("b54_58", v, 5'b10101);
        v = 0;
        for (int i = 52; i <= 59; i++) v = v * 2 + (obs[i] & 1);
        chk("a52_59", v, 8'b0111_1110);

        // Wrap into a second, randomly latched frame, then drop enable at 30/2
        run_ticks(300, 1);
        guard = 0;
        while (!(m_sec == 30 && m_slot == 2) && guard < 700) begin
            step(1, 1, 1);
            guard++;
        end
        chk("reach_sec30_slot2", guard < 700 ? 1 : 0, 1);
        step(0, 1, 0);
        step(0, 0, 0);
        rand_fields();
        step(1, 1, 0);
        run_ticks(80, 1);

        // Park at a slot-0 (carrier off) position, then async reset mid-cycle
        guard = 0;
        while (m_slot != 0 && guard < 20) begin step(1, 1, 0); guard++; end
        repeat (2) step(1, 0, 0);
        @(negedge clk);
        chk("pre_reset_carrier", int'(carrier), 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_carrier", int'(carrier), 1);
        chk("async_sec", int'(sec), 0);
        chk("async_bits_valid", int'(bits_valid), 0);
        chk("async_bits_data", int'(bits_data), 0);
        m_run = 0; m_sec = 0; m_slot = 0;
        @(posedge clk); #1;
        enable = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step(0, 1, 0);
        rand_fields();
        step(1, 1, 0);
        run_ticks(40, 1);

        repeat (4) step(1, 0, 0);
        chk("pending_carrier_exp", cq.size(), 0);
        chk("pending_bits_exp", bq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
